// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner: matrix keypad scanner with debounce, keymap decode and digit-entry buffer.
// Define KEYPAD_BACKSPACE_EN to make * delete the newest digit instead of clearing the entry.
module keypad_entry_scanner #(
    parameter int ROWS = 4,
    parameter int COLS = 3,
    parameter int MAX_DIGITS = 20,
    parameter int SETTLE_CYC = 2,
    parameter int DEBOUNCE_CYC = 50,
    parameter int TIMEOUT_CYC = 5000,
    parameter logic [ROWS*COLS*4-1:0] KEYMAP = 48'hB0A987654321
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [COLS-1:0]                 col_n,
    output logic [ROWS-1:0]                 row_n,
    output logic [4*MAX_DIGITS-1:0]         digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count,
    output logic                            key_valid,
    output logic [3:0]                      key_code,
    output logic                            entry_valid,
    output logic [1:0]                      entry_status
);
    // dwell covers the settle time plus the two synchroniser stages, so the sample belongs to this row
    localparam int DWELL = SETTLE_CYC + 2;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(DWELL);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int NW = $clog2(MAX_DIGITS + 1);
    localparam int BW = 4 * MAX_DIGITS;
`ifdef KEYPAD_BACKSPACE_EN
    localparam bit BACKSPACE = 1'b1;
`else
    localparam bit BACKSPACE = 1'b0;
`endif

    typedef enum logic [2:0] {SCAN, DEBOUNCE, DECODE, RELEASE, TOUT} state_t;
    state_t state, nstate;

    logic [COLS-1:0] col_s1, col_s, key_cols;
    logic [RW-1:0]   row;
    logic [CW-1:0]   cidx;
    logic [SW-1:0]   scnt;
    logic [DW-1:0]   dcnt;
    logic [TW-1:0]   tcnt;
    logic [BW-1:0]   buffer;
    logic [NW-1:0]   count;
    logic            ovf;
    logic [3:0]      code_new;

    wire last_dwell = scnt == SW'(DWELL - 1);
    wire single     = $onehot(~col_s);
    wire stable     = col_s == ~key_cols;
    wire released   = &col_s;
    wire deb_done   = dcnt == DW'(DEBOUNCE_CYC - 1);
    wire timed_out  = count != '0 && tcnt == TW'(TIMEOUT_CYC - 1);
    wire is_digit   = code_new <= 4'd9;
    wire ends_entry = key_code == 4'hB || (!BACKSPACE && key_code == 4'hA);

    always_comb begin
        cidx = '0;
        for (int i = 0; i < COLS; i++) if (key_cols[i]) cidx = CW'(i);
        code_new = KEYMAP[4*(int'(row)*COLS + int'(cidx)) +: 4];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= SCAN;
        else state <= enable ? nstate : SCAN;

    always_comb begin
        nstate = state;
        case (state)
            SCAN:     nstate = timed_out ? TOUT : (last_dwell && single) ? DEBOUNCE : SCAN;
            DEBOUNCE: nstate = !stable ? SCAN : deb_done ? DECODE : DEBOUNCE;
            DECODE:   nstate = RELEASE;
            RELEASE:  nstate = (released && deb_done) ? SCAN : RELEASE;
            default:  nstate = SCAN;
        endcase
    end

    always_comb begin
        row_n        = ~(ROWS'(1) << row);
        key_valid    = state == DECODE;
        entry_valid  = state == TOUT || (state == DECODE && ends_entry);
        entry_status = !entry_valid ? 2'd0 : state == TOUT ? 2'd2 : key_code == 4'hA ? 2'd1 : ovf ? 2'd3 : 2'd0;
        digits       = state == TOUT ? {MAX_DIGITS{4'hE}} : buffer;
        digit_count  = count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {col_s, col_s1} <= '1;
            {row, scnt, dcnt, tcnt, count, ovf, key_cols} <= '0;
            buffer   <= '1;
            key_code <= 4'hF;
        end else if (!enable) begin
            {col_s, col_s1} <= '1;
            {row, scnt, dcnt, tcnt, count, ovf, key_cols} <= '0;
            buffer   <= '1;
            key_code <= 4'hF;
        end else begin
            col_s1 <= col_n;
            col_s  <= col_s1;
            case (state)
                SCAN: begin
                    scnt <= last_dwell ? '0 : scnt + 1'b1;
                    tcnt <= count != '0 ? tcnt + 1'b1 : tcnt;
                    if (nstate == DEBOUNCE) key_cols <= ~col_s;
                    else if (last_dwell) row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
                end
                DEBOUNCE: begin
                    dcnt <= nstate == DEBOUNCE ? dcnt + 1'b1 : '0;
                    if (nstate == DECODE) begin
                        key_code <= code_new;
                        if (is_digit && count == NW'(MAX_DIGITS)) ovf <= 1'b1;
                        else if (is_digit) begin
                            buffer <= {buffer[BW-5:0], code_new};
                            count  <= count + 1'b1;
                        end else if (BACKSPACE && code_new == 4'hA && count != '0) begin
                            buffer <= {4'hF, buffer[BW-1:4]};
                            count  <= count - 1'b1;
                        end
                    end
                end
                DECODE: begin
                    tcnt <= '0;
                    if (ends_entry) begin
                        buffer <= '1;
                        count  <= '0;
                        ovf    <= 1'b0;
                    end
                end
                RELEASE: dcnt <= (nstate == SCAN || !released) ? '0 : dcnt + 1'b1;
                default: begin
                    tcnt   <= '0;
                    buffer <= '1;
                    count  <= '0;
                    ovf    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_entry_scanner.sv
// tb_keypad_entry_scanner: random key entry against a digit-queue reference model with a scoreboard.
module tb_keypad_entry_scanner;
    localparam int ROWS = 4, COLS = 3, MAXD = 4;

    logic            clk = 0, rst = 1, enable = 1;
    logic [COLS-1:0] col_n;
    logic [ROWS-1:0] row_n;
    logic [15:0]     digits;
    logic [2:0]      digit_count;
    logic            key_valid, entry_valid;
    logic [3:0]      key_code;
    logic [1:0]      entry_status;
    logic            pressed [ROWS][COLS];

    typedef struct {
        bit         is_entry;
        logic [3:0] code;
        logic [1:0] status;
        logic [15:0] digits;
        logic [2:0] count;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  dq[$];
    bit  ovf;
    int  vectors = 0, miscompares = 0, kv_seen = 0, ev_seen = 0;
    int  kv0, e0;

    keypad_entry_scanner #(.ROWS(ROWS), .COLS(COLS), .MAX_DIGITS(MAXD), .SETTLE_CYC(2),
                           .DEBOUNCE_CYC(4), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .enable(enable), .col_n(col_n), .row_n(row_n),
        .digits(digits), .digit_count(digit_count), .key_valid(key_valid), .key_code(key_code),
        .entry_valid(entry_valid), .entry_status(entry_status));

    always #5 clk = ~clk;

    // passive keypad: a pressed key shorts its column to the driven (low) row
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_row_n"}, 32'(row_n), 32'hE);
        check({tag, "_digits"}, 32'(digits), 32'hFFFF);
        check({tag, "_count"}, 32'(digit_count), 0);
        check({tag, "_key_valid"}, 32'(key_valid), 0);
        check({tag, "_key_code"}, 32'(key_code), 32'hF);
        check({tag, "_entry_valid"}, 32'(entry_valid), 0);
        check({tag, "_entry_status"}, 32'(entry_status), 0);
    endtask

    function automatic logic [15:0] model_digits();
        logic [15:0] d = '1;
        foreach (dq[i]) d[4*i +: 4] = dq[i][3:0];
        return d;
    endfunction

    task automatic expect_ev(input bit is_entry, input logic [3:0] code, input logic [1:0] status,
                             input logic [15:0] d);
        ev_t e;
        e = '{is_entry, code, status, d, 3'(dq.size())};
        sb.push_back(e);
    endtask

    task automatic model_key(input int code);
        if (code <= 9) begin
            if (dq.size() < MAXD) dq.push_front(code);
            else ovf = 1;
            expect_ev(0, 4'(code), 2'd0, model_digits());
        end else if (code == 11) begin
            expect_ev(0, 4'hB, 2'd0, model_digits());
            expect_ev(1, 4'hB, ovf ? 2'd3 : 2'd0, model_digits());
            dq.delete();
            ovf = 0;
        end else begin
`ifdef KEYPAD_BACKSPACE_EN
            if (dq.size() > 0) void'(dq.pop_front());
            expect_ev(0, 4'hA, 2'd0, model_digits());
`else
            expect_ev(0, 4'hA, 2'd0, model_digits());
            expect_ev(1, 4'hA, 2'd1, model_digits());
            dq.delete();
            ovf = 0;
`endif
        end
    endtask

    function automatic int key_index(input int code);
        return code == 0 ? 10 : code == 10 ? 9 : code == 11 ? 11 : code - 1;
    endfunction

    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pressed[r][c] = 0;
    endtask

    task automatic press(input int code, input int bounces);
        int k, r, c;
        k = key_index(code);
        r = k / COLS;
        c = k % COLS;
        model_key(code);
        repeat (bounces) begin
            pressed[r][c] = 1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            pressed[r][c] = 0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        pressed[r][c] = 1;
        repeat (40) @(negedge clk);
        pressed[r][c] = 0;
        repeat (20) @(negedge clk);
    endtask

    always @(negedge clk) if (!rst) begin
        if (key_valid) begin
            kv_seen++;
            if (sb.size() == 0 || sb[0].is_entry) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_key_valid: got code %h expected no key", key_code);
            end else begin
                mon_e = sb.pop_front();
                check("key_code", 32'(key_code), 32'(mon_e.code));
                check("key_digits", 32'(digits), 32'(mon_e.digits));
                check("key_count", 32'(digit_count), 32'(mon_e.count));
            end
        end
        if (entry_valid) begin
            ev_seen++;
            if (sb.size() == 0 || !sb[0].is_entry) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_entry_valid: got status %0d expected no entry", entry_status);
            end else begin
                mon_e = sb.pop_front();
                check("entry_status", 32'(entry_status), 32'(mon_e.status));
                check("entry_digits", 32'(digits), 32'(mon_e.digits));
            end
        end
    end

    initial begin
        int seq1[] = '{1, 2, 3, 11};
        int seq2[] = '{1, 2, 3, 4, 5, 11};
        int seq3[] = '{4, 6, 10};
        clear_keys();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 0;
        foreach (seq1[i]) press(seq1[i], 0);
        kv0 = kv_seen;
        press(5, 2);
        check("bounce_one_key", kv_seen - kv0, 1);
        check("bounce_count", 32'(digit_count), 1);
        press(11, 0);
        foreach (seq2[i]) press(seq2[i], 0);
        press(7, 0);
        expect_ev(1, 4'h0, 2'd2, 16'hEEEE);
        dq.delete();
        ovf = 0;
        e0 = ev_seen;
        for (int i = 0; i < 300 && ev_seen == e0; i++) @(negedge clk);
        check("timeout_fired", ev_seen - e0, 1);
        @(negedge clk);
        check("timeout_digits", 32'(digits), 32'hFFFF);
        check("timeout_count", 32'(digit_count), 0);
        foreach (seq3[i]) press(seq3[i], 0);
`ifdef KEYPAD_BACKSPACE_EN
        check("star_digits", 32'(digits), 32'hFFF4);
        check("star_count", 32'(digit_count), 1);
        press(10, 0);
`endif
        check("star_cleared", 32'(digits), 32'hFFFF);
        kv0 = kv_seen;
        pressed[0][0] = 1;
        pressed[0][1] = 1;
        repeat (40) @(negedge clk);
        clear_keys();
        repeat (20) @(negedge clk);
        check("multikey_rejected", kv_seen - kv0, 0);
        for (int e = 0; e < 6; e++) begin
            int n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++) press($urandom_range(0, 10), $urandom_range(0, 2));
            press(11, $urandom_range(0, 2));
        end
        check("scoreboard_drained", sb.size(), 0);
        rst = 1;
        @(negedge clk);
        pressed[0][1] = 1;
        rst = 0;
        kv0 = kv_seen;
        repeat (6) @(negedge clk);
        rst = 1;
        #1;
        check_reset("mid_debounce_reset");
        check("mid_debounce_no_key", kv_seen - kv0, 0);
        clear_keys();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
